fifo_tx_reader: RTL

Read-side drain controller for the async FIFO in the UART TX clock domain. Pops one byte at a time from the FIFO read port (`rinc`/`rd_data`/`rempty`) and hands it to the UART transmitter over a level valid/busy handshake. Enforces one pop per transmitted frame and a programmable inter-frame gap. Keeps a running frame counter for status readback.

---
 rtl/fifo_tx_reader.sv | 84 ++++++++
 1 files changed

// File: rtl/fifo_tx_reader.sv
// Read-side drain controller: pops one FIFO word per UART TX frame, hands it over a
// level valid/busy handshake, inserts an idle gap between frames and counts frames.
module fifo_tx_reader #(
    parameter int unsigned data_width = 8,
    parameter int unsigned IDLE_GAP   = 2
) (
    input  logic                  rclk,
    input  logic                  rrst,
    input  logic                  en,
    input  logic                  rempty,
    input  logic [data_width-1:0] rd_data,
    output logic                  rinc,
    output logic [data_width-1:0] tx_data,
    output logic                  tx_valid,
    input  logic                  tx_busy,
    output logic                  active,
    output logic [15:0]           frame_cnt
);

    typedef enum logic [1:0] {
        StIdle,
        StSend,
        StBusy,
        StGap
    } state_t;

    // Last gap count before returning to idle; unused when IDLE_GAP is 0.
    localparam logic [3:0] GapLast = (IDLE_GAP > 0) ? 4'(IDLE_GAP - 1) : 4'd0;

    state_t     state;
    logic [3:0] gap_cnt;

    always_ff @(posedge rclk or posedge rrst) begin
        if (rrst) begin
            state     <= StIdle;
            gap_cnt   <= 4'd0;
            rinc      <= 1'b0;
            tx_data   <= '0;
            tx_valid  <= 1'b0;
            active    <= 1'b0;
            frame_cnt <= 16'd0;
        end else begin
            case (state)
                StIdle: begin
                    if (en && !rempty) begin
                        tx_data  <= rd_data;
                        rinc     <= 1'b1;
                        tx_valid <= 1'b1;
                        active   <= 1'b1;
                        state    <= StSend;
                    end
                end
                StSend: begin
                    rinc <= 1'b0;
                    if (tx_busy) begin
                        tx_valid <= 1'b0;
                        state    <= StBusy;
                    end
                end
                StBusy: begin
                    if (!tx_busy) begin
                        frame_cnt <= frame_cnt + 16'd1;
                        if (IDLE_GAP > 0) begin
                            gap_cnt <= 4'd0;
                            state   <= StGap;
                        end else begin
                            active <= 1'b0;
                            state  <= StIdle;
                        end
                    end
                end
                StGap: begin
                    gap_cnt <= gap_cnt + 4'd1;
                    if (gap_cnt == GapLast) begin
                        active <= 1'b0;
                        state  <= StIdle;
                    end
                end
                default: state <= StIdle;
            endcase
        end
    end

endmodule
